// File: rtl/dvi_link_sequencer_pkg.sv
// rtl/dvi_link_sequencer_pkg.sv - state encodings and shared constants for the DVI link sequencer
package dvi_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_SETTLE    = 3'd2,
    ST_WARM      = 3'd3,
    ST_ACTIVE    = 3'd4,
    ST_DRAIN     = 3'd5
  } state_t;

  localparam logic [7:0] ERR_SAT = 8'hFF;

  function automatic logic tg_run_of(input state_t s);
    return (s == ST_WARM) || (s == ST_ACTIVE) || (s == ST_DRAIN);
  endfunction

  function automatic logic tmds_en_of(input state_t s);
    return (s == ST_ACTIVE) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/dvi_link_sequencer_if.sv
// rtl/dvi_link_sequencer_if.sv - video-side signals between sequencer, timing generator and serializer
interface dvi_link_sequencer_if;
  logic       VD_i;
  logic [2:0] PAT_SEL_i;
  logic       TG_RUN_o;
  logic       TMDS_EN_o;
  logic [2:0] PAT_o;

  modport master (
    input  VD_i, PAT_SEL_i,
    output TG_RUN_o, TMDS_EN_o, PAT_o
  );

  modport slave (
    output VD_i, PAT_SEL_i,
    input  TG_RUN_o, TMDS_EN_o, PAT_o
  );
endinterface

// File: rtl/dvi_link_sequencer_sync_2ff.sv
// rtl/dvi_link_sequencer_sync_2ff.sv - two-flop synchronizer with async active-high clear
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/dvi_link_sequencer.sv
// rtl/dvi_link_sequencer.sv - PLL/enable bring-up sequencer gating timing generator and TMDS output
module dvi_link_sequencer
  import dvi_seq_pkg::*;
#(
  parameter int SETTLE_CYC  = 1024,
  parameter int WARM_FRAMES = 2
) (
  input  logic                 CK,
  input  logic                 AR,
  input  logic                 PLL_LOCK_i,
  input  logic                 EN_i,
  dvi_link_sequencer_if.master vid,
  output logic [2:0]           STATE_o,
  output logic [7:0]           ERR_CNT_o
);
  localparam int CW = $clog2(SETTLE_CYC + 1);

  logic          lock_s, en_s;
  logic          vd_d, vd_rise;
  logic          lock_loss;
  state_t        state, state_nxt;
  logic [CW-1:0] cyc_cnt;
  logic [7:0]    frame_cnt;
  logic          tg_run, tmds_en;
  logic [2:0]    pat;

  sync_2ff u_sync_lock (.clk(CK), .rst(AR), .d(PLL_LOCK_i), .q(lock_s));
  sync_2ff u_sync_en   (.clk(CK), .rst(AR), .d(EN_i),       .q(en_s));

  assign vd_rise = vid.VD_i & ~vd_d;

  // WAIT_LOCK is excluded: sitting there unlocked is the expected wait, not a loss event.
  assign lock_loss = !lock_s && (state == ST_SETTLE || state == ST_WARM ||
                                 state == ST_ACTIVE || state == ST_DRAIN);

  always_comb begin
    state_nxt = state;
    if (lock_loss) begin
      state_nxt = ST_WAIT_LOCK;
    end else begin
      case (state)
        ST_IDLE:      if (en_s) state_nxt = ST_WAIT_LOCK;
        ST_WAIT_LOCK: if (!en_s) state_nxt = ST_IDLE;
                      else if (lock_s) state_nxt = ST_SETTLE;
        ST_SETTLE:    if (!en_s) state_nxt = ST_IDLE;
                      else if (cyc_cnt == CW'(SETTLE_CYC - 1)) state_nxt = ST_WARM;
        ST_WARM:      if (!en_s) state_nxt = ST_IDLE;
                      else if (vd_rise && ({1'b0, frame_cnt} + 9'd1 == 9'(WARM_FRAMES)))
                        state_nxt = ST_ACTIVE;
        ST_ACTIVE:    if (!en_s) state_nxt = ST_DRAIN;
        ST_DRAIN:     if (vd_rise) state_nxt = ST_IDLE;
        default:      state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CK or posedge AR) begin
    if (AR) begin
      state     <= ST_IDLE;
      vd_d      <= 1'b0;
      cyc_cnt   <= '0;
      frame_cnt <= '0;
      tg_run    <= 1'b0;
      tmds_en   <= 1'b0;
      pat       <= '0;
      ERR_CNT_o <= '0;
    end else begin
      state   <= state_nxt;
      vd_d    <= vid.VD_i;
      tg_run  <= tg_run_of(state_nxt);
      tmds_en <= tmds_en_of(state_nxt);

      if (state == ST_SETTLE && state_nxt == ST_SETTLE)
        cyc_cnt <= cyc_cnt + 1'b1;
      else
        cyc_cnt <= '0;

      if (state == ST_WARM && state_nxt == ST_WARM) begin
        if (vd_rise) frame_cnt <= frame_cnt + 8'd1;
      end else begin
        frame_cnt <= '0;
      end

      if (lock_loss && ERR_CNT_o != ERR_SAT)
        ERR_CNT_o <= ERR_CNT_o + 8'd1;

      // Pattern only changes on a frame boundary so a frame is never split between patterns.
      if (vd_rise && (state == ST_ACTIVE || (state == ST_WARM && state_nxt == ST_ACTIVE)))
        pat <= vid.PAT_SEL_i;
    end
  end

  assign STATE_o       = state;
  assign vid.TG_RUN_o  = tg_run;
  assign vid.TMDS_EN_o = tmds_en;
  assign vid.PAT_o     = pat;
endmodule
